// File: rtl/tcm_dec_trb_pkg.sv
// Shared types and helpers for the trellis traceback decision pipe:
// the modular metric compare and the tree latency calculation.
package tcm_dec_trb_pkg;

  // Reference sizes for the default 64-state, 10-bit metric configuration
  localparam int cMETRIC_W  = 10;
  localparam int cSTATE_NUM = 64;
  localparam int cSTATEB_W  = $clog2(cSTATE_NUM);

  // Metrics are zero-extended to this width before the modular compare
  localparam int cCMP_W = 32;

  typedef logic [cMETRIC_W-1:0] statem_t;
  typedef logic [cSTATEB_W-1:0] stateb_t;

  // Returns 1 when candidate a wins over b. The difference is taken modulo
  // 2^width and read as signed. Max mode: a wins on d >= 0. Min mode: a wins
  // on d <= 0. Equal metrics always keep a, the lower index.
  function automatic logic statem_a_max(
    input logic [cCMP_W-1:0] a,
    input logic [cCMP_W-1:0] b,
    input int unsigned       width,
    input logic              mode
  );
    logic [cCMP_W-1:0] mask;
    logic [cCMP_W-1:0] diff;
    logic              neg;
    logic              zero;
    mask = (cCMP_W'(1) << width) - cCMP_W'(1);
    diff = (a - b) & mask;
    neg  = diff[width-1];
    zero = (diff == '0);
    return mode ? (neg || zero) : !neg;
  endfunction

  // Enabled-clock latency of a tree over state_num candidates with a
  // register every stride levels and always one after the last level.
  function automatic int tree_latency(input int state_num, input int stride);
    int depth;
    depth = $clog2(state_num);
    return (depth + stride - 1) / stride;
  endfunction

endpackage

// File: rtl/tcm_dec_trb_decision_pipe_if.sv
// Metric-vector input and decision output bundle of the decision pipe.
interface tcm_dec_trb_decision_pipe_if #(
  parameter int pSTATE_NUM = 64,
  parameter int pMETRIC_W  = 10,
  parameter int pTAG_W     = 8
);
  localparam int cIDX_W = $clog2(pSTATE_NUM);

  logic                            ival;
  logic [pSTATE_NUM*pMETRIC_W-1:0] istatem;
  logic [pTAG_W-1:0]               itag;
  logic                            oval;
  logic [cIDX_W-1:0]               ostate;
  logic [pMETRIC_W-1:0]            ometric;
  logic [pTAG_W-1:0]               otag;

  // Producer side (ACS unit / testbench)
  modport master (
    output ival, istatem, itag,
    input  oval, ostate, ometric, otag
  );

  // Decision pipe side
  modport slave (
    input  ival, istatem, itag,
    output oval, ostate, ometric, otag
  );
endinterface

// File: rtl/tcm_dec_trb_cmp_node.sv
// Combinational 2:1 compare node: forwards metric and state index of the
// winning candidate, a being the lower-index side.
module tcm_dec_trb_cmp_node
  import tcm_dec_trb_pkg::*;
#(
  parameter int pMETRIC_W = 10,
  parameter int pIDX_W    = 6,
  parameter int pMODE_MIN = 0
) (
  input  logic [pMETRIC_W-1:0] i_a_metric,
  input  logic [pIDX_W-1:0]    i_a_idx,
  input  logic [pMETRIC_W-1:0] i_b_metric,
  input  logic [pIDX_W-1:0]    i_b_idx,
  output logic [pMETRIC_W-1:0] o_metric,
  output logic [pIDX_W-1:0]    o_idx
);

  logic w_a_win;

  assign w_a_win  = statem_a_max(cCMP_W'(i_a_metric), cCMP_W'(i_b_metric),
                                 pMETRIC_W, pMODE_MIN != 0);
  assign o_metric = w_a_win ? i_a_metric : i_b_metric;
  assign o_idx    = w_a_win ? i_a_idx    : i_b_idx;

endmodule

// File: rtl/tcm_dec_trb_decision_pipe.sv
// Best-state search over a full path-metric vector: a pipelined binary
// compare tree in modular arithmetic returning best index, its metric and
// a sideband tag aligned with the decision.
module tcm_dec_trb_decision_pipe
  import tcm_dec_trb_pkg::*;
#(
  parameter int pSTATE_NUM  = 64,
  parameter int pMETRIC_W   = 10,
  parameter int pREG_STRIDE = 1,
  parameter int pMODE_MIN   = 0,
  parameter int pTAG_W      = 8
) (
  input  logic                        iclk,
  input  logic                        ireset,
  input  logic                        iclkena,
  tcm_dec_trb_decision_pipe_if.slave  bus
);

  localparam int cD     = $clog2(pSTATE_NUM);
  localparam int cIDX_W = cD;
  // All candidates of all levels live in one flat array: level k starts at
  // offset 2N - 2*(N >> k) and holds N >> k entries; the final winner is last.
  localparam int cCAND  = 2 * pSTATE_NUM - 1;

  logic [pMETRIC_W-1:0] w_cand_m [cCAND];
  logic [cIDX_W-1:0]    w_cand_i [cCAND];
  logic                 w_lvl_val [cD+1];
  logic [pTAG_W-1:0]    w_lvl_tag [cD+1];

  genvar gi, gj;

  // Level 0 candidates: raw metrics tagged with their own state index
  for (gi = 0; gi < pSTATE_NUM; gi++) begin : gen_src
    assign w_cand_m[gi] = bus.istatem[gi*pMETRIC_W +: pMETRIC_W];
    assign w_cand_i[gi] = cIDX_W'(gi);
  end

  assign w_lvl_val[0] = bus.ival;
  assign w_lvl_tag[0] = bus.itag;

  for (gi = 0; gi < cD; gi++) begin : gen_lvl
    localparam int cNODES   = pSTATE_NUM >> (gi + 1);
    localparam int cIN_OFS  = 2 * pSTATE_NUM - 2 * (pSTATE_NUM >> gi);
    localparam int cOUT_OFS = 2 * pSTATE_NUM - 2 * cNODES;

    logic [pMETRIC_W-1:0] w_node_m [cNODES];
    logic [cIDX_W-1:0]    w_node_i [cNODES];

    for (gj = 0; gj < cNODES; gj++) begin : gen_node
      tcm_dec_trb_cmp_node #(
        .pMETRIC_W (pMETRIC_W),
        .pIDX_W    (cIDX_W),
        .pMODE_MIN (pMODE_MIN)
      ) u_node (
        .i_a_metric (w_cand_m[cIN_OFS + 2*gj]),
        .i_a_idx    (w_cand_i[cIN_OFS + 2*gj]),
        .i_b_metric (w_cand_m[cIN_OFS + 2*gj + 1]),
        .i_b_idx    (w_cand_i[cIN_OFS + 2*gj + 1]),
        .o_metric   (w_node_m[gj]),
        .o_idx      (w_node_i[gj])
      );
    end

    if (((gi + 1) % pREG_STRIDE) == 0 || gi == cD - 1) begin : gen_reg
      logic                 r_val;
      logic [pTAG_W-1:0]    r_tag;
      logic [pMETRIC_W-1:0] r_m [cNODES];
      logic [cIDX_W-1:0]    r_i [cNODES];

      // Stage register: valid shifts every enabled cycle, tag and data only
      // load with a valid entry so the outputs hold the last decision
      always_ff @(posedge iclk) begin
        if (ireset) begin
          r_val <= 1'b0;
          r_tag <= '0;
          for (int n = 0; n < cNODES; n++) begin
            r_m[n] <= '0;
            r_i[n] <= '0;
          end
        end else if (iclkena) begin
          r_val <= w_lvl_val[gi];
          if (w_lvl_val[gi]) begin
            r_tag <= w_lvl_tag[gi];
            for (int n = 0; n < cNODES; n++) begin
              r_m[n] <= w_node_m[n];
              r_i[n] <= w_node_i[n];
            end
          end
        end
      end

      assign w_lvl_val[gi+1] = r_val;
      assign w_lvl_tag[gi+1] = r_tag;
      for (gj = 0; gj < cNODES; gj++) begin : gen_out
        assign w_cand_m[cOUT_OFS + gj] = r_m[gj];
        assign w_cand_i[cOUT_OFS + gj] = r_i[gj];
      end
    end else begin : gen_comb
      assign w_lvl_val[gi+1] = w_lvl_val[gi];
      assign w_lvl_tag[gi+1] = w_lvl_tag[gi];
      for (gj = 0; gj < cNODES; gj++) begin : gen_out
        assign w_cand_m[cOUT_OFS + gj] = w_node_m[gj];
        assign w_cand_i[cOUT_OFS + gj] = w_node_i[gj];
      end
    end
  end

  assign bus.oval    = w_lvl_val[cD];
  assign bus.otag    = w_lvl_tag[cD];
  assign bus.ometric = w_cand_m[cCAND-1];
  assign bus.ostate  = w_cand_i[cCAND-1];

endmodule

// File: doc/tcm_dec_trb_decision_pipe.md
Name: tcm_dec_trb_decision_pipe

Overview:
- Parametrised successor to the 4D-8PSK trellis traceback path decision tree.
- Every valid cycle it takes the full vector of path metrics (one per trellis state) and finds the best state with a binary compare tree in modulo (wrap-around) arithmetic.
- Returns the best state index and its metric, with a sideband tag carried alongside.
- Generalised over state count, metric width, pipeline register stride and max/min selection; sits between the ACS unit and traceback start-state logic.

Parameters:
- pSTATE_NUM, 64, number of trellis states; power of 2, at least 2.
- pMETRIC_W, 10, metric width in bits; metrics are modulo-normalised.
- pREG_STRIDE, 1, tree levels between pipeline registers; 1 ≤ stride ≤ log2(pSTATE_NUM).
- pMODE_MIN, 0, selection mode: 0 = best is modular maximum, 1 = best is modular minimum.
- pTAG_W, 8, width of the sideband tag carried with each decision.

Ports:
- iclk, input, 1, clock.
- ireset, input, 1, synchronous active-high reset.
- iclkena, input, 1, clock enable; low freezes all state.
- ival, input, 1, input metric vector valid.
- istatem, input, pSTATE_NUM*pMETRIC_W, packed metrics; state s occupies bits [s*W +: W].
- itag, input, pTAG_W, sideband tag, captured with ival.
- oval, output, 1, decision valid.
- ostate, output, log2(pSTATE_NUM), best state index.
- ometric, output, pMETRIC_W, metric of the best state.
- otag, output, pTAG_W, tag aligned with the decision.

Behaviour:
- One clock, iclk. ireset is synchronous, active-high.
- Reset:
  - all valid and data registers clear to 0;
  - oval = 0, ostate = 0, ometric = 0, otag = 0 on the first edge with ireset high;
  - ireset takes priority over iclkena;
  - reset mid-operation discards all in-flight decisions; no oval pulse appears for them.
- Tree shape:
  - D = log2(pSTATE_NUM) levels; level k halves the candidate count;
  - pair j at level k compares candidates 2j and 2j+1 of level k-1;
  - level 0 uses the raw states.
- Compare rule, modulo arithmetic:
  - d = (a − b) mod 2^W, interpreted as a signed value;
  - a wins if d ≥ 0 when pMODE_MIN = 0, or if d ≤ 0 when pMODE_MIN = 1.
  - Ties choose a, the lower index. The overall result is therefore the lowest index among equal best metrics.
- Each candidate carries its metric and its original state index; the winner forwards both.
- Pipeline:
  - registers sit after levels stride−1, 2·stride−1, …, and always after the last level D−1;
  - latency L = ceil(D / pREG_STRIDE) cycles of enabled clock; for pSTATE_NUM=64, stride 1 → L=6; stride 3 → L=2; stride 6 → L=1.
- Valid and tag:
  - a shift chain of length L carries ival and itag;
  - oval is the last element of the valid chain; otag comes from the tag chain.
- Data register loading:
  - a stage's data registers load only when iclkena = 1 and that stage's incoming valid = 1; otherwise they hold;
  - the outputs therefore keep the last decision while oval = 0.
- Throughput and enable:
  - one decision per enabled cycle, back-to-back; no backpressure;
  - iclkena = 0 freezes valid, data and tag; the pipeline resumes without loss when iclkena returns to 1.
- The modular compare is valid only while the metric spread is below 2^(W−1); that bound is guaranteed by ACS normalisation upstream and is not checked here.

Decomposition:
- Shared package tcm_dec_trb_pkg:
  - statem_t (pMETRIC_W bits);
  - stateb_t (log2 state count);
  - function statem_a_max(a, b, mode) implementing the modular compare and tie rule;
  - function tree_latency(state_num, stride).
- One sub-module, tcm_dec_trb_cmp_node: a combinational 2:1 node taking (metric, index) pairs in and returning the winner's (metric, index). It is instantiated per node through a generate loop.
- Level-to-register mapping is done by generate conditions on (level+1) % stride == 0 or level == D−1.

Test Plan:
- Basic max: N=16, W=8, stride 1, max mode; all metrics 0x10 except state 11 = 0x40, tag 0xA5 → 4 cycles later oval=1, ostate=11, ometric=0x40, otag=0xA5.
- Modular wrap: max mode; state 3 = 0x7F, state 9 = 0x81, all others 0x70 → ostate=9, ometric=0x81 (0x81−0x7F=+2). Same vector in min mode → ostate=9 loses to the others; min is state 0 = 0x70 (lowest index among ties).
- Tie rule: all 16 metrics = 0x55 → ostate=0. States 6 and 13 = 0x60, others 0x20 → ostate=6.
- Throughput and stride: N=64, stride 3; 20 back-to-back random vectors compared against a reference model → 20 consecutive oval pulses starting 2 cycles after the first ival, each matching the model.
- Clock enable and bubbles: ival pattern 1,0,1,1 with iclkena low for 3 cycles mid-stream → oval pulses preserve order and spacing in enabled cycles; outputs hold during gaps.
- Reset mid-flight: ireset asserted 2 cycles after ival with L=4 → no oval ever appears for that vector; all outputs 0 on the next edge.
